// File: rtl/axis_video_out.sv
// AXI-Stream RGB565 video sink: buffers beats in a small FIFO and regenerates
// hsync/vsync/de for the display, locking the stream to the raster via tuser/tlast.
module axis_video_out #(
    parameter int   H_ACTIVE   = 1024,
    parameter int   H_FP       = 24,
    parameter int   H_SYNC     = 136,
    parameter int   H_BP       = 160,
    parameter int   V_ACTIVE   = 768,
    parameter int   V_FP       = 3,
    parameter int   V_SYNC     = 6,
    parameter int   V_BP       = 29,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   FIFO_DEPTH = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        ce,
    input  logic        en,
    input  logic [15:0] tdata_s,
    input  logic        tlast_s,
    input  logic        tuser_s,
    input  logic        tvalid_s,
    output logic        tready_s,
    output logic [15:0] vid_data,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic        vid_de,
    output logic        err_underflow,
    output logic        err_desync,
    input  logic        err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [11:0] H_TOTAL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] V_TOTAL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        SYNC,
        ARM,
        RUN
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [17:0] mem [FIFO_DEPTH];
    logic [17:0] head;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop_slot;
    logic        pop;
    logic        active;
    logic        at_origin;
    logic        at_line_end;
    logic        frame_end;
    logic        set_underflow;
    logic        set_desync;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head        = mem[rd_ptr[AW-1:0]];
    assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign at_origin   = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    assign at_line_end = (h_cnt == H_ACT - 12'd1);
    assign frame_end   = (h_cnt == H_TOTAL - 12'd1) && (v_cnt == V_TOTAL - 12'd1);

    // While hunting for a frame start every beat is taken so junk drains quickly
    assign tready_s = !hreset && en && ((state == SYNC) || !full);
    assign push     = tvalid_s && tready_s && ((state != SYNC) || tuser_s);
    assign pop_slot = ce && en && active && (state == RUN);
    assign pop      = pop_slot && !empty;

    always_ff @(posedge hclk) begin
        if (hreset || !en) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else if (ce) begin
            if (h_cnt == H_TOTAL - 12'd1) begin
                h_cnt <= 12'd0;
                v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        set_underflow = 1'b0;
        set_desync    = 1'b0;
        case (state)
            SYNC: if (push) state_next = ARM;
            ARM:  if (ce && frame_end) state_next = RUN;
            RUN: begin
                if (pop_slot) begin
                    if (empty) begin
                        set_underflow = 1'b1;
                        state_next    = SYNC;
                    end else if ((head[17] != at_origin) || (head[16] != at_line_end)) begin
                        set_desync = 1'b1;
                        state_next = SYNC;
                    end
                end
            end
            default: state_next = SYNC;
        endcase
        if (!en) begin
            state_next    = SYNC;
            set_underflow = 1'b0;
            set_desync    = 1'b0;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) state <= SYNC;
        else        state <= state_next;
    end

    // Pulling rd_ptr up to wr_ptr flushes; in SYNC this keeps only a freshly pushed frame start
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if ((state == SYNC) || (state_next == SYNC)) rd_ptr <= wr_ptr;
            else if (pop)                                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {tuser_s, tlast_s, tdata_s};
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            vid_data <= 16'd0;
            vid_de   <= 1'b0;
            vid_hs   <= ~SYNC_POL;
            vid_vs   <= ~SYNC_POL;
        end else if (ce) begin
            vid_hs   <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vid_vs   <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            vid_de   <= active && en && (state == RUN);
            vid_data <= pop ? head[15:0] : 16'd0;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset || err_clr) begin
            err_underflow <= 1'b0;
            err_desync    <= 1'b0;
        end else begin
            if (set_underflow) err_underflow <= 1'b1;
            if (set_desync)    err_desync    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_video_out.sv
// Bench for axis_video_out on a reduced raster: a timing model checks the sync outputs
// every cycle and a scoreboard of {position, data} checks every displayed pixel.
module tb_axis_video_out;
    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 1;
    localparam int VA  = 4;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        ce;
    logic        en;
    logic [15:0] tdata_s;
    logic        tlast_s;
    logic        tuser_s;
    logic        tvalid_s;
    logic        tready_s;
    logic [15:0] vid_data;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_de;
    logic        err_underflow;
    logic        err_desync;
    logic        err_clr;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          de_cnt = 0;
    int          ce_phase = 0;
    bit          ce_slow = 1'b0;
    bit          mon_on = 1'b0;
    bit          hs_acc;
    logic [17:0] tx_q[$];
    logic [31:0] exp_q[$];

    int          mh = 0;
    int          mv = 0;
    int          e_pos = 0;
    logic        e_hs;
    logic        e_vs;
    logic        e_act;
    logic        new_out = 1'b0;

    axis_video_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1'b0), .FIFO_DEPTH(16)
    ) dut (
        .hclk(hclk), .hreset(hreset), .ce(ce), .en(en),
        .tdata_s(tdata_s), .tlast_s(tlast_s), .tuser_s(tuser_s), .tvalid_s(tvalid_s),
        .tready_s(tready_s),
        .vid_data(vid_data), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .err_underflow(err_underflow), .err_desync(err_desync), .err_clr(err_clr)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference raster: counters and registered sync levels derived from the timing formulas
    always @(posedge hclk) begin
        new_out <= hreset || ce;
        if (hreset || !en) begin
            mh <= 0;
            mv <= 0;
        end else if (ce) begin
            if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
        if (hreset) begin
            e_hs  <= 1'b1;
            e_vs  <= 1'b1;
            e_act <= 1'b0;
        end else if (ce) begin
            e_hs  <= !(mh >= HA + HF && mh < HA + HF + HSW);
            e_vs  <= !(mv >= VA + VF && mv < VA + VF + VSW);
            e_act <= (mh < HA) && (mv < VA);
            e_pos <= mv * HA + mh;
        end
    end

    always @(negedge hclk) begin : monitor
        logic [31:0] e;
        if (mon_on) begin
            checkOutput("hsync", vid_hs, e_hs);
            checkOutput("vsync", vid_vs, e_vs);
            checkOutput("de_outside_active", vid_de && !e_act, 0);
            if (!vid_de) checkOutput("data_blank", vid_data, 0);
            if (new_out && vid_de) begin
                de_cnt++;
                checkOutput("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("pix_data", vid_data, e[15:0]);
                    checkOutput("pix_pos", e_pos, e[31:16]);
                end
            end
        end
    end

    initial begin
        ce = 1'b1;
        forever begin
            @(posedge hclk);
            #1;
            ce_phase = (ce_phase + 1) % 4;
            ce = ce_slow ? (ce_phase == 0) : 1'b1;
        end
    end

    initial begin
        tvalid_s = 1'b0;
        tdata_s  = 16'd0;
        tlast_s  = 1'b0;
        tuser_s  = 1'b0;
        forever begin
            @(negedge hclk);
            hs_acc = tvalid_s && tready_s;
            @(posedge hclk);
            #1;
            if (hs_acc) void'(tx_q.pop_front());
            if (tx_q.size() > 0) begin
                tvalid_s = 1'b1;
                {tuser_s, tlast_s, tdata_s} = tx_q[0];
            end else begin
                tvalid_s = 1'b0;
            end
        end
    end

    // Queue a run of counting pixels; expected pixels go to the scoreboard when asked
    task automatic applyStimulus(input int first, input int count, input int bad_tlast, input bit expect_out);
        for (int i = first; i < first + count; i++) begin
            int p;
            p = i % (HA * VA);
            tx_q.push_back({p == 0, ((p % HA) == HA - 1) || (p == bad_tlast), 16'(p)});
            if (expect_out) exp_q.push_back({16'(p), 16'(p)});
        end
    endtask

    task automatic waitSbEmpty(input int maxc, input string tag);
        for (int i = 0; i < maxc && exp_q.size() != 0; i++) @(negedge hclk);
        checkOutput(tag, exp_q.size(), 0);
    endtask

    task automatic waitFlag(input bit desync_sel, input int maxc, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge hclk);
            if ((desync_sel ? err_desync : err_underflow) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(ok), 1);
    endtask

    task automatic waitEdge(input bit vs_sel, input logic level, input string tag, output int when);
        logic prev;
        logic cur;
        bit   ok = 1'b0;
        when = 0;
        prev = vs_sel ? vid_vs : vid_hs;
        for (int i = 0; i < 2000; i++) begin
            @(negedge hclk);
            cur = vs_sel ? vid_vs : vid_hs;
            if (cur === level && prev !== level) begin
                ok   = 1'b1;
                when = cyc;
                break;
            end
            prev = cur;
        end
        checkOutput(tag, 32'(ok), 1);
    endtask

    task automatic restartBlock();
        @(posedge hclk);
        #1 en = 1'b0;
        @(negedge hclk);
        checkOutput("tready_en_low", tready_s, 0);
        repeat (3) @(posedge hclk);
        #1 en = 1'b1;
    endtask

    initial begin
        int t0, t1, t2;
        int de0;
        hreset  = 1'b1;
        en      = 1'b1;
        err_clr = 1'b0;

        $display("[TB] reset");
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        checkOutput("rst_tready", tready_s, 0);
        checkOutput("rst_de", vid_de, 0);
        checkOutput("rst_data", vid_data, 0);
        checkOutput("rst_hs", vid_hs, 1);
        checkOutput("rst_vs", vid_vs, 1);
        checkOutput("rst_err_underflow", err_underflow, 0);
        checkOutput("rst_err_desync", err_desync, 0);
        @(posedge hclk);
        #1 hreset = 1'b0;
        mon_on = 1'b1;
        @(negedge hclk);
        checkOutput("tready_sync", tready_s, 1);

        $display("[TB] free-running timing, no stream");
        waitEdge(1'b0, 1'b0, "hs_fall_seen", t0);
        waitEdge(1'b0, 1'b1, "hs_rise_seen", t1);
        waitEdge(1'b0, 1'b0, "hs_fall2_seen", t2);
        checkOutput("hs_width", t1 - t0, HSW);
        checkOutput("line_period", t2 - t0, HT);
        waitEdge(1'b1, 1'b0, "vs_fall_seen", t0);
        waitEdge(1'b1, 1'b1, "vs_rise_seen", t1);
        waitEdge(1'b1, 1'b0, "vs_fall2_seen", t2);
        checkOutput("vs_width", t1 - t0, VSW * HT);
        checkOutput("frame_period", t2 - t0, VT * HT);
        checkOutput("timing_no_de", de_cnt, 0);

        $display("[TB] two frames of counting pixels");
        de0 = de_cnt;
        applyStimulus(0, 2 * HA * VA, -1, 1'b1);
        waitSbEmpty(1000, "two_frames_drained");
        checkOutput("two_frames_de_count", de_cnt - de0, 2 * HA * VA);
        checkOutput("two_frames_underflow", err_underflow, 0);
        checkOutput("two_frames_desync", err_desync, 0);
        restartBlock();

        $display("[TB] leading garbage before frame start");
        for (int i = 0; i < 5; i++) tx_q.push_back({2'b00, 16'hBAD0 + 16'(i)});
        applyStimulus(0, HA * VA, -1, 1'b1);
        waitSbEmpty(1000, "garbage_frame_drained");
        checkOutput("garbage_underflow", err_underflow, 0);
        checkOutput("garbage_desync", err_desync, 0);
        restartBlock();

        $display("[TB] source stall mid-line");
        applyStimulus(0, 20, -1, 1'b1);
        exp_q.push_back({16'd20, 16'd0});
        waitFlag(1'b0, 1000, "underflow_set");
        repeat (20) @(posedge hclk);
        applyStimulus(20, HA * VA - 20, -1, 1'b0);
        applyStimulus(0, HA * VA, -1, 1'b1);
        waitSbEmpty(1000, "relock_frame_drained");
        checkOutput("underflow_sticky", err_underflow, 1);
        checkOutput("stall_no_desync", err_desync, 0);
        @(posedge hclk);
        #1 err_clr = 1'b1;
        @(posedge hclk);
        #1 err_clr = 1'b0;
        @(negedge hclk);
        checkOutput("underflow_cleared", err_underflow, 0);
        restartBlock();

        $display("[TB] ce one in four, misplaced tlast");
        ce_slow = 1'b1;
        waitEdge(1'b0, 1'b0, "slow_hs_fall_seen", t0);
        waitEdge(1'b0, 1'b1, "slow_hs_rise_seen", t1);
        waitEdge(1'b0, 1'b0, "slow_hs_fall2_seen", t2);
        checkOutput("slow_hs_width", t1 - t0, 4 * HSW);
        checkOutput("slow_line_period", t2 - t0, 4 * HT);
        applyStimulus(0, HA * VA, HA + 6, 1'b0);
        for (int p = 0; p <= HA + 6; p++) exp_q.push_back({16'(p), 16'(p)});
        waitFlag(1'b1, 4000, "desync_set");
        waitSbEmpty(20, "desync_pixels_drained");
        checkOutput("desync_no_underflow", err_underflow, 0);
        repeat (2 * 4 * HT * VT) @(posedge hclk);
        @(negedge hclk);
        checkOutput("desync_sticky", err_desync, 1);
        checkOutput("desync_back_in_sync_tready", tready_s, 1);
        checkOutput("desync_no_extra_pixels", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
